dout_uart_logger: RTL and testbench

//  Consumer end of the CPU Dout/Dval output port. Captures each new Dout value

---
 rtl/dout_uart_logger_pkg.sv | 19 +
 rtl/dout_uart_logger_uart_tx_8n1.sv | 101 ++++++++++
 rtl/dout_uart_logger.sv | 113 +++++++++++
 tb/tb_dout_uart_logger.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dout_uart_logger_pkg.sv
// Shared types and helpers for the Dout/Dval UART logger: transmitter state
// encoding, drop-counter ceiling and the baud divider calculation.
package dout_uart_logger_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] DROPS_MAX = 8'd255;

    // Clock cycles per UART bit; truncating division.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/dout_uart_logger_uart_tx_8n1.sv
// 8N1 UART transmitter: baud counter, LSB-first shift register and a
// four-state FSM; state is exposed on State for observation.
module uart_tx_8n1
    import dout_uart_logger_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Data,
    output logic       Tx,
    output logic       Busy,
    output logic [1:0] State
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          baud_end;

    assign baud_end = (cnt_q == CNT_LAST);

    // Start/Busy handshake: Start is a valid strobe that is consumed only
    // while the FSM is IDLE (Busy low); Data must be stable in that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != TX_IDLE) begin
            cnt_d = baud_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            TX_IDLE: begin
                if (Start) begin
                    state_d = TX_START;
                    shift_d = Data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (baud_end) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (baud_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign Tx    = tx_q;
    assign Busy  = busy_q;
    assign State = state_q;

endmodule

// File: rtl/dout_uart_logger.sv
// Logs CPU Dout values qualified by Dval: change/re-arm capture, a small
// FIFO with sticky overflow and saturating drop count, and an 8N1 UART.
module dout_uart_logger
    import dout_uart_logger_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               Dout,
    input  logic                     Dval,
    input  logic                     Clear,
    output logic                     Tx,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Overflow,
    output logic [7:0]               Drops
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    last_q;
    logic          armed_q;
    logic          overflow_q;
    logic [7:0]    drops_q;

    logic [1:0]    tx_state;
    logic          full, empty, capture, pop, push, drop;

    assign full    = (count_q == LVL_FULL);
    assign empty   = (count_q == '0);
    // A repeat of the last value is only logged after Dval has dropped once.
    assign capture = Dval && (armed_q || (Dout != last_q));
    assign pop     = (tx_state == TX_IDLE) && !empty;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_q  <= 8'd0;
            armed_q <= 1'b1;
        end else if (capture) begin
            last_q  <= Dout;
            armed_q <= 1'b0;
        end else if (!Dval) begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wptr_q] <= Dout;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop in the same cycle as Clear still registers, counting from zero.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            overflow_q <= 1'b0;
            drops_q    <= 8'd0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (Clear) begin
                drops_q <= 8'd1;
            end else if (drops_q != DROPS_MAX) begin
                drops_q <= drops_q + 8'd1;
            end
        end else if (Clear) begin
            overflow_q <= 1'b0;
            drops_q    <= 8'd0;
        end
    end

    uart_tx_8n1 #(
        .DIV(DIV)
    ) u_tx (
        .Clock (Clock),
        .Reset (Reset),
        .Start (pop),
        .Data  (mem[rptr_q]),
        .Tx    (Tx),
        .Busy  (Busy),
        .State (tx_state)
    );

    assign Level    = count_q;
    assign Overflow = overflow_q;
    assign Drops    = drops_q;

endmodule

// File: tb/tb_dout_uart_logger.sv
// Bench for dout_uart_logger with DIV=4, DEPTH=4: directed steps plus random
// traffic against a queue-based model of capture, FIFO, flags and UART timing.
module tb_dout_uart_logger;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       Clock;
    logic       Reset;
    logic [7:0] Dout;
    logic       Dval;
    logic       Clear;
    logic       Tx;
    logic       Busy;
    logic [2:0] Level;
    logic       Overflow;
    logic [7:0] Drops;

    dout_uart_logger #(
        .CLK_HZ(1000),
        .BAUD  (250),
        .DEPTH (DEPTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Dout     (Dout),
        .Dval     (Dval),
        .Clear    (Clear),
        .Tx       (Tx),
        .Busy     (Busy),
        .Level    (Level),
        .Overflow (Overflow),
        .Drops    (Drops)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last;
    logic       m_armed;
    logic [7:0] m_cur;
    int         m_left;
    logic       m_ovf;
    int         m_drops;

    // Line receiver state
    logic       rx_act;
    int         rx_n;
    logic [7:0] rx_byte;
    int         rx_frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_last  = 8'd0;
        m_armed = 1'b1;
        m_cur   = 8'd0;
        m_left  = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        rx_act  = 1'b0;
        rx_n    = 0;
    endtask

    function automatic logic model_tx();
        int idx;
        int k;
        if (m_left == 0) return 1'b1;
        idx = FRAME - m_left;
        k   = idx / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic cycle();
        logic       pop, cap, full, push, drop, dv, clr;
        logic [7:0] din;
        logic [7:0] e;
        @(posedge Clock);
        dv  = Dval;
        din = Dout;
        clr = Clear;
        if (!Reset) begin
            full = (m_q.size() == DEPTH);
            pop  = (m_left == 0) && (m_q.size() != 0);
            cap  = dv && (m_armed || (din != m_last));
            push = cap && (!full || pop);
            drop = cap && full && !pop;
            if (cap) begin
                m_last  = din;
                m_armed = 1'b0;
            end else if (!dv) begin
                m_armed = 1'b1;
            end
            if (pop) begin
                m_cur  = m_q.pop_front();
                exp_q.push_back(m_cur);
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (push) m_q.push_back(din);
            if (clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        #1;
        if (!Reset) begin
            chk("tx", Tx, model_tx());
            chk("busy", Busy, m_left > 0);
            chk("level", Level, m_q.size());
            chk("overflow", Overflow, m_ovf);
            chk("drops", Drops, m_drops);
            if (rx_act) begin
                rx_n++;
                for (int k = 0; k < 8; k++) begin
                    if (rx_n == DIV * (k + 1) + DIV / 2) rx_byte[k] = Tx;
                end
                if (rx_n == 9 * DIV + DIV / 2) begin
                    chk("stop_bit", Tx, 1);
                    rx_act = 1'b0;
                    rx_frames++;
                    e = 'x;
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    chk("rx_byte", rx_byte, e);
                end
            end else if (Tx == 1'b0) begin
                rx_act = 1'b1;
                rx_n   = 0;
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        chk({tag, "_tx"}, Tx, 1);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_level"}, Level, 0);
        chk({tag, "_ovf"}, Overflow, 0);
        chk({tag, "_drops"}, Drops, 0);
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         f0;
        logic [7:0] b;
        logic       found;
        rx_frames = 0;
        rx_byte   = 8'd0;
        model_reset();
        Reset = 1'b1;
        Dval  = 1'b0;
        Dout  = 8'd0;
        Clear = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_tx", Tx, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_level", Level, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_drops", Drops, 0);
        Reset = 1'b0;
        cycle();

        // Single byte: latency, frame length
        f0 = rx_frames;
        Dval = 1'b1;
        Dout = 8'hA5;
        cycle();
        chk("a5_level1", Level, 1);
        chk("a5_tx_t1", Tx, 1);
        Dval = 1'b0;
        cycle();
        chk("a5_tx_t2", Tx, 0);
        chk("a5_level0", Level, 0);
        chk("a5_busy_first", Busy, 1);
        repeat (39) cycle();
        chk("a5_busy_last", Busy, 1);
        cycle();
        chk("a5_busy_end", Busy, 0);
        repeat (3) cycle();
        chk("a5_frames", rx_frames - f0, 1);

        // Held value logs once; after a Dval gap it logs again
        f0 = rx_frames;
        Dval = 1'b1;
        Dout = 8'h3C;
        repeat (20) cycle();
        Dval = 1'b0;
        cycle();
        Dval = 1'b1;
        cycle();
        Dval = 1'b0;
        repeat (130) cycle();
        chk("held_frames", rx_frames - f0, 2);

        // Burst into a 4-deep FIFO: two drops
        f0 = rx_frames;
        for (int i = 1; i <= 7; i++) begin
            Dval = 1'b1;
            Dout = 8'(i);
            cycle();
        end
        Dval = 1'b0;
        chk("burst_ovf", Overflow, 1);
        chk("burst_drops", Drops, 2);
        chk("burst_level", Level, 4);
        repeat (215) cycle();
        chk("burst_frames", rx_frames - f0, 5);
        chk("burst_drained", exp_q.size(), 0);

        Clear = 1'b1;
        cycle();
        Clear = 1'b0;
        chk("clear_ovf", Overflow, 0);
        chk("clear_drops", Drops, 0);

        // Full FIFO with capture and pop in the same cycle
        b = 8'h40;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            b++;
            Dout = b;
            Dval = 1'b1;
            cycle();
            if (Busy == 1'b0 && Level == 3'd4) found = 1'b1;
        end
        chk("fullpop_found", found, 1);
        b++;
        Dout = b;
        cycle();
        chk("fullpop_level", Level, 4);
        chk("fullpop_nodrop", Drops, m_drops);
        chk("fullpop_busy", Busy, 1);

        // Drop counter saturation
        repeat (320) begin
            b++;
            Dout = b;
            cycle();
        end
        chk("sat_drops", Drops, 255);
        chk("sat_ovf", Overflow, 1);
        Dval = 1'b0;
        repeat (220) cycle();

        // Reset in the middle of a frame
        Dval = 1'b1;
        Dout = 8'hFF;
        cycle();
        Dout = 8'h00;
        cycle();
        Dval = 1'b0;
        repeat (14) cycle();
        chk("mid_busy_before", Busy, 1);
        chk("mid_level_before", Level, 1);
        apply_reset("midrst");
        f0 = rx_frames;
        Dval = 1'b1;
        Dout = 8'hFF;
        cycle();
        Dval = 1'b0;
        repeat (45) cycle();
        chk("rearm_frames", rx_frames - f0, 1);

        // Random traffic with repeats and occasional Clear
        repeat (600) begin
            Dval  = ($urandom_range(0, 3) != 0);
            Dout  = 8'($urandom_range(0, 3));
            Clear = ($urandom_range(0, 31) == 0);
            cycle();
        end
        Dval  = 1'b0;
        Clear = 1'b0;
        repeat (250) cycle();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_level", Level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
